// File: rtl/snake_pkg.sv
// Shared direction definitions for the snake input path.
// Contents: direction encodings, bus widths, opposite-direction helper.
package snake_pkg;

  localparam int unsigned DIR_W = 2;
  localparam int unsigned KEY_W = 4;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Opposite direction shares the axis bit and flips the sense bit.
  function automatic logic [DIR_W-1:0] opposite_dir(input logic [DIR_W-1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Pending direction-command FIFO.
// Ports: clk, rst (async active-low), push_i/din_i write at tail,
//        pop_i reads head (ignored when empty), head_o oldest entry,
//        tail_o newest entry, count_o occupancy (0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DIR_W-1:0]         din_i,
  output logic [DIR_W-1:0]         head_o,
  output logic [DIR_W-1:0]         tail_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DIR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // Pointer and occupancy next-state; power-of-two DEPTH wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign tail_o  = mem_q[wr_ptr_q - AW'(1)];
  assign count_o = count_q;

endmodule

// File: rtl/dir_input_queue.sv
// Snake direction input queue: reduces button presses to one candidate,
// filters repeats against the newest pending direction, queues survivors
// and applies one per game tick.
// Ports: clk, rst (async active-low), key_down[3:0] press pulses
//        (bit0 up, bit1 down, bit2 left, bit3 right), game_tick pop request,
//        dir applied direction, dir_changed load pulse, q_count occupancy,
//        overflow dropped-press pulse.
// Option: define DIR_REVERSE_REJECT_EN to also discard direct reversals.
module dir_input_queue
  import snake_pkg::*;
#(
  parameter int unsigned      DEPTH     = 4,
  parameter logic [DIR_W-1:0] RESET_DIR = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_W-1:0]       key_down,
  input  logic                   game_tick,
  output logic [DIR_W-1:0]       dir,
  output logic                   dir_changed,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DIR_W-1:0] dir_q, dir_d;
  logic             dir_changed_q, dir_changed_d;
  logic             overflow_q, overflow_d;

  logic [DIR_W-1:0] cand;
  logic             cand_valid;
  logic [DIR_W-1:0] ref_dir;
  logic             reject;
  logic             accept;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [DIR_W-1:0] head, tail;
  logic [CW-1:0]    count;

  // Same-cycle presses collapse to one candidate: up > down > left > right.
  always_comb begin
    cand_valid = 1'b1;
    cand       = DIR_UP;
    if      (key_down[0]) cand = DIR_UP;
    else if (key_down[1]) cand = DIR_DOWN;
    else if (key_down[2]) cand = DIR_LEFT;
    else if (key_down[3]) cand = DIR_RIGHT;
    else                  cand_valid = 1'b0;
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));

  // Filter against what dir will eventually become: newest pending entry.
  assign ref_dir = fifo_empty ? dir_q : tail;

`ifdef DIR_REVERSE_REJECT_EN
  assign reject = (cand == ref_dir) || (cand == opposite_dir(ref_dir));
`else
  assign reject = (cand == ref_dir);
`endif

  assign accept = cand_valid && !reject;
  assign pop    = game_tick && !fifo_empty;
  assign push   = accept && (!fifo_full || pop);

  // Applied direction and one-cycle pulses.
  always_comb begin
    dir_d         = dir_q;
    dir_changed_d = 1'b0;
    overflow_d    = accept && fifo_full && !pop;
    if (pop) begin
      dir_d         = head;
      dir_changed_d = (head != dir_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q         <= RESET_DIR;
      dir_changed_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      dir_changed_q <= dir_changed_d;
      overflow_q    <= overflow_d;
    end
  end

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (cand),
    .head_o  (head),
    .tail_o  (tail),
    .count_o (count)
  );

  assign dir         = dir_q;
  assign dir_changed = dir_changed_q;
  assign overflow    = overflow_q;
  assign q_count     = count;

endmodule

// File: tb/tb_dir_input_queue.sv
// Self-checking bench for dir_input_queue: directed scenarios plus a
// randomized run against a queue-based behavioural model.
// Honours DIR_REVERSE_REJECT_EN when expecting reversal filtering.
module tb_dir_input_queue;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [1:0]  RST_DIR = 2'b11;
`ifdef DIR_REVERSE_REJECT_EN
  localparam bit REV_REJ = 1'b1;
`else
  localparam bit REV_REJ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    key_down = 4'b0;
  logic          game_tick = 1'b0;
  logic [1:0]    dir;
  logic          dir_changed;
  logic [CW-1:0] q_count;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] mq[$];
  logic [1:0] m_dir;
  logic       m_chg;
  logic       m_ovf;

  always #5 clk = ~clk;

  dir_input_queue #(
    .DEPTH     (DEPTH),
    .RESET_DIR (RST_DIR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .game_tick   (game_tick),
    .dir         (dir),
    .dir_changed (dir_changed),
    .q_count     (q_count),
    .overflow    (overflow)
  );

  function automatic void model_reset();
    mq.delete();
    m_dir = RST_DIR;
    m_chg = 1'b0;
    m_ovf = 1'b0;
  endfunction

  // One clock of the intended behaviour, expressed on a plain queue.
  function automatic void model_step(input logic [3:0] k, input logic t);
    logic [1:0] c;
    logic [1:0] r;
    logic [1:0] h;
    bit         v;
    v = (k != 4'b0);
    c = k[0] ? 2'd0 : k[1] ? 2'd1 : k[2] ? 2'd2 : 2'd3;
    r = (mq.size() > 0) ? mq[$] : m_dir;
    if (v && (c == r || (REV_REJ && c == {r[1], ~r[0]}))) v = 1'b0;
    m_chg = 1'b0;
    m_ovf = 1'b0;
    if (t && mq.size() > 0) begin
      h = mq.pop_front();
      m_chg = (h != m_dir);
      m_dir = h;
    end
    if (v) begin
      if (mq.size() < int'(DEPTH)) mq.push_back(c);
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic drive(input logic [3:0] k, input logic t);
    @(negedge clk);
    key_down  = k;
    game_tick = t;
    @(posedge clk);
    model_step(k, t);
    #1;
    key_down  = 4'b0;
    game_tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #2 rst = 1'b0;
    #3;
    n_cmp++; if (dir !== RST_DIR) begin n_err++; $display("FAIL reset_dir got %b exp %b", dir, RST_DIR); end
    n_cmp++; if (q_count !== CW'(0)) begin n_err++; $display("FAIL reset_count got %0d exp 0", q_count); end
    n_cmp++; if (dir_changed !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_pulses got chg=%b ovf=%b exp 0 0", dir_changed, overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 1'b1);
    n_cmp++; if (dir !== 2'b11 || dir_changed !== 1'b0 || q_count !== CW'(0)) begin n_err++; $display("FAIL idle_tick got dir=%b chg=%b cnt=%0d exp 11 0 0", dir, dir_changed, q_count); end
  endtask

  task automatic test_single_press();
    apply_reset();
    drive(4'b0001, 1'b0);
    n_cmp++; if (q_count !== CW'(1) || dir !== 2'b11) begin n_err++; $display("FAIL single_push got cnt=%0d dir=%b exp 1 11", q_count, dir); end
    drive(4'b0000, 1'b1);
    n_cmp++; if (q_count !== CW'(0) || dir !== 2'b00 || dir_changed !== 1'b1) begin n_err++; $display("FAIL single_pop got cnt=%0d dir=%b chg=%b exp 0 00 1", q_count, dir, dir_changed); end
    drive(4'b0000, 1'b0);
    n_cmp++; if (dir_changed !== 1'b0 || dir !== 2'b00) begin n_err++; $display("FAIL single_pulse_end got chg=%b dir=%b exp 0 00", dir_changed, dir); end
  endtask

  task automatic test_priority();
    apply_reset();
    drive(4'b0101, 1'b0);
    n_cmp++; if (q_count !== CW'(1)) begin n_err++; $display("FAIL priority_count got %0d exp 1", q_count); end
    drive(4'b0000, 1'b1);
    n_cmp++; if (dir !== 2'b00) begin n_err++; $display("FAIL priority_dir got %b exp 00", dir); end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_dirs [4];
    exp_dirs[0] = 2'b00; exp_dirs[1] = 2'b10; exp_dirs[2] = 2'b01; exp_dirs[3] = 2'b10;
    apply_reset();
    drive(4'b0001, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b0100, 1'b0);
    n_cmp++; if (q_count !== CW'(4) || overflow !== 1'b0) begin n_err++; $display("FAIL fill_count got cnt=%0d ovf=%b exp 4 0", q_count, overflow); end
    drive(4'b1000, 1'b0);
    // Right is the reversal of the newest entry (left) when reversals are filtered.
    n_cmp++; if (q_count !== CW'(4) || overflow !== !REV_REJ) begin n_err++; $display("FAIL overflow_pulse got cnt=%0d ovf=%b exp 4 %b", q_count, overflow, !REV_REJ); end
    drive(4'b0000, 1'b0);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL overflow_once got %b exp 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 1'b1);
      n_cmp++; if (dir !== exp_dirs[i] || dir_changed !== 1'b1 || q_count !== CW'(3 - i)) begin
        n_err++; $display("FAIL drain_%0d got dir=%b chg=%b cnt=%0d exp %b 1 %0d", i, dir, dir_changed, q_count, exp_dirs[i], 3 - i);
      end
    end
  endtask

  task automatic test_reverse();
    apply_reset();
    drive(4'b0100, 1'b0);
    n_cmp++; if (q_count !== (REV_REJ ? CW'(0) : CW'(1))) begin n_err++; $display("FAIL reverse_filter got %0d exp %0d", q_count, REV_REJ ? 0 : 1); end
    apply_reset();
    drive(4'b1000, 1'b0);
    n_cmp++; if (q_count !== CW'(0)) begin n_err++; $display("FAIL repeat_filter got %0d exp 0", q_count); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    drive(4'b0001, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0001, 1'b1);
    n_cmp++; if (q_count !== CW'(4) || overflow !== 1'b0 || dir !== 2'b00 || dir_changed !== 1'b1) begin
      n_err++; $display("FAIL full_push_pop got cnt=%0d ovf=%b dir=%b chg=%b exp 4 0 00 1", q_count, overflow, dir, dir_changed);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (q_count !== CW'(0) || dir !== 2'b11 || dir_changed !== 1'b0) begin n_err++; $display("FAIL mid_reset got cnt=%0d dir=%b chg=%b exp 0 11 0", q_count, dir, dir_changed); end
    @(negedge clk);
    rst = 1'b1;
    drive(4'b0000, 1'b1);
    n_cmp++; if (q_count !== CW'(0) || dir !== 2'b11) begin n_err++; $display("FAIL post_reset_tick got cnt=%0d dir=%b exp 0 11", q_count, dir); end
  endtask

  task automatic test_random();
    logic [3:0] k;
    logic       t;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      k = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      t = ($urandom_range(0, 4) == 0);
      drive(k, t);
      n_cmp++; if (dir !== m_dir || dir_changed !== m_chg || overflow !== m_ovf || q_count !== CW'(mq.size())) begin
        n_err++; $display("FAIL random_%0d got dir=%b chg=%b ovf=%b cnt=%0d exp %b %b %b %0d", i, dir, dir_changed, overflow, q_count, m_dir, m_chg, m_ovf, mq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_priority();
    test_overflow();
    test_reverse();
    test_full_push_pop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dir_input_queue.md
DIR_INPUT_QUEUE -- requirements
Module: dir_input_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set pending-command queue entries (power of 2, 2..16).
REQ-002 Parameter RESET_DIR, default 2'b11, SHALL set the direction loaded at reset (00 up, 01 down, 10 left, 11 right).
REQ-003 clk  input  1  SHALL be the single clock; all logic on rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 key_down  input  4  SHALL be per-button press pulses from four debouncers; bit0 up, bit1 down, bit2 left, bit3 right.
REQ-006 game_tick  input  1  SHALL be a one-cycle pulse marking a snake step, i.e. the pop request.
REQ-007 dir  output  2  SHALL be the registered, currently applied direction.
REQ-008 dir_changed  output  1  SHALL pulse for one cycle when dir takes a new value.
REQ-009 q_count  output  $clog2(DEPTH)+1  SHALL be the number of queued commands.
REQ-010 overflow  output  1  SHALL pulse for one cycle when an accepted press is dropped because the queue is full.

Function
REQ-011 Same-cycle multiple key_down bits SHALL be reduced to one candidate by priority up > down > left > right; the others SHALL be discarded.
REQ-012 The reference direction for filtering SHALL be the newest queued entry, or dir if the queue is empty; when a push and a pop occur in the same cycle, the reference SHALL still be the newest entry before the pop.
REQ-013 A candidate equal to the reference direction SHALL be discarded without a push.
REQ-014 A surviving candidate SHALL be pushed at the tail, with q_count incremented on the next edge.
REQ-015 If the queue is full and no pop occurs in the same cycle, a surviving candidate SHALL be dropped and overflow SHALL pulse on the next cycle.
REQ-016 On game_tick with a non-empty queue, the head SHALL be popped and loaded into dir on the next edge; dir_changed SHALL pulse in that same cycle.
REQ-017 On game_tick with an empty queue, dir SHALL be held and dir_changed SHALL stay 0.
REQ-018 game_tick and a push in the same cycle SHALL both take effect.
- A full queue SHALL accept the push: q_count unchanged, no overflow.
- An empty queue SHALL NOT bypass: the pushed entry SHALL wait for the next tick.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; q_count SHALL never exceed DEPTH or underflow.
REQ-020 Press-to-dir latency SHALL be the time to the next game_tick, plus one cycle, plus one tick per older queued entry.

Reset
REQ-021 While rst=0, the block SHALL set dir=RESET_DIR, dir_changed=0, overflow=0, q_count=0, and both pointers to 0.
REQ-022 Reset asserted mid-operation SHALL discard all queued entries immediately; queue storage contents need not be reset.
REQ-023 Key pulses and ticks coincident with the first edge after reset release SHALL be processed normally.

Configuration
REQ-024 With macro DIR_REVERSE_REJECT_EN defined, a candidate that is the opposite of the reference direction (bit1 equal, bit0 flipped) SHALL be discarded like a repeat.
REQ-025 Without DIR_REVERSE_REJECT_EN, opposite-direction candidates SHALL be queued; only exact repeats SHALL be discarded.

Structure
REQ-026 The direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT and the opposite-direction function SHALL live in shared package snake_pkg.
REQ-027 The queue SHALL be sub-module dir_fifo (parameter DEPTH; push/pop/data in/out/count).
REQ-028 Priority reduction, filtering, and dir/pulse registers SHALL stay in dir_input_queue.

Verification
REQ-029 After reset, tick with no keys -> dir=11, dir_changed=0, q_count=0.
REQ-030 key_down=0001, then tick -> q_count=1, then 0 one cycle after the tick; dir=00; one dir_changed pulse.
REQ-031 key_down=0101 in one cycle -> only up queued, q_count=1.
REQ-032 Queue sequence up, left, down, left (DEPTH=4), then press right -> overflow pulses once, q_count stays 4; four ticks yield dir 00, 10, 01, 10.
REQ-033 With dir=11, press left, once with DIR_REVERSE_REJECT_EN defined and once without -> q_count 0 (defined) / 1 (undefined).
REQ-034 Full queue, press plus game_tick in the same cycle -> head popped, new entry at tail, q_count=4, overflow=0; assert rst mid-sequence -> q_count=0, dir=11.
